// File: rtl/rv_dff_en.sv
// rtl/rv_dff_en.sv - enabled D flip-flop bank with mux-hold or clock-gated enable
//
// Generic WIDTH-bit storage register used for control regs and register-file
// entries. Two enable styles are selected by GATED:
//   GATED=0 : free-running clock, the flop recirculates its own value when en=0.
//   GATED=1 : en is captured by a transparent-low latch and gates the clock;
//             scan_mode forces the gate open so the bank shifts every edge.
// With scan_mode=0 both styles are cycle-identical from din/en to dout.
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous active-high reset, loads RESET_VAL
//   en         in   1      load enable, din is captured on the next rising edge
//   scan_mode  in   1      gate override (GATED=1 only, ignored otherwise)
//   din        in   WIDTH  next-state data
//   dout       out  WIDTH  registered data
module rv_dff_en #(
  parameter int               WIDTH     = 1,
  parameter bit               GATED     = 1'b0,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             scan_mode,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] dout_d;
  logic [WIDTH-1:0] dout_q;

  if (GATED == 1'b0) begin : g_mux_hold
    // The clock is never gated here, so scan_mode has no function.
    logic unused_scan_mode;
    assign unused_scan_mode = scan_mode;

    always_comb begin
      dout_d = dout_q;
      if (en) begin
        dout_d = din;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        dout_q <= RESET_VAL;
      end else begin
        dout_q <= dout_d;
      end
    end
  end else begin : g_clock_gate
    logic en_q;
    logic gclk;

    // Transparent while clk is low, so en is frozen for the whole high phase
    // and any glitch on en during that phase cannot reach the gated clock.
    // Held at 0 in reset so the gated clock stays quiet coming out of reset.
    always_latch begin
      if (rst) begin
        en_q <= 1'b0;
      end else if (!clk) begin
        en_q <= en;
      end
    end

    assign gclk = clk & (en_q | scan_mode);

    // Every gated edge is a load; the hold comes from the missing edge.
    always_comb begin
      dout_d = din;
    end

    always_ff @(posedge gclk or posedge rst) begin
      if (rst) begin
        dout_q <= RESET_VAL;
      end else begin
        dout_q <= dout_d;
      end
    end
  end

  assign dout = dout_q;

`ifdef ASSERT_ON
  if (WIDTH < 1) begin : g_width_chk
    $error("rv_dff_en: WIDTH must be at least 1");
  end

  a_ctrl_known: assert property (@(posedge clk) disable iff (rst)
    !$isunknown({en, scan_mode}))
    else $error("rv_dff_en: en or scan_mode is X/Z at clock edge");
`endif

endmodule

// File: tb/tb_rv_dff_en.sv
// tb/tb_rv_dff_en.sv - scoreboard bench for rv_dff_en, mux-hold and gated variants
module tb_rv_dff_en;

  localparam logic [31:0] RV_HI = 32'h8000_0000;

  logic        clk;
  logic        rst;
  logic        en;
  logic        scan_mode;
  logic [31:0] din;
  logic [31:0] dout_s;
  logic [31:0] dout_g;
  logic [31:0] dout_r;
  logic [31:0] dout_rg;
  logic [0:0]  dout_b;

  rv_dff_en #(.WIDTH(32), .GATED(1'b0), .RESET_VAL(32'h0)) u_s (
    .clk(clk), .rst(rst), .en(en), .scan_mode(scan_mode), .din(din), .dout(dout_s));
  rv_dff_en #(.WIDTH(32), .GATED(1'b1), .RESET_VAL(32'h0)) u_g (
    .clk(clk), .rst(rst), .en(en), .scan_mode(scan_mode), .din(din), .dout(dout_g));
  rv_dff_en #(.WIDTH(1), .GATED(1'b0), .RESET_VAL(1'b0)) u_b (
    .clk(clk), .rst(rst), .en(en), .scan_mode(scan_mode), .din(din[0:0]), .dout(dout_b));
  rv_dff_en #(.WIDTH(32), .GATED(1'b0), .RESET_VAL(RV_HI)) u_r (
    .clk(clk), .rst(rst), .en(en), .scan_mode(scan_mode), .din(din), .dout(dout_r));
  rv_dff_en #(.WIDTH(32), .GATED(1'b1), .RESET_VAL(RV_HI)) u_rg (
    .clk(clk), .rst(rst), .en(en), .scan_mode(scan_mode), .din(din), .dout(dout_rg));

  typedef struct {
    string       tag;
    logic [31:0] s;
    logic [31:0] g;
    logic [31:0] r;
    logic [31:0] rg;
    logic        b;
  } exp_t;

  exp_t edge_q[$];
  exp_t async_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: the value each instance must hold after the next edge.
  logic [31:0] m_s, m_g, m_r, m_rg;
  logic        m_b;

  bit          t2_en [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
  bit          t2_din[4] = '{1'b1, 1'b1, 1'b0, 1'b1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t snap(string tag);
    exp_t e;
    e.tag = tag;
    e.s   = m_s;
    e.g   = m_g;
    e.r   = m_r;
    e.rg  = m_rg;
    e.b   = m_b;
    return e;
  endfunction

  task automatic model_reset();
    m_s  = 32'h0;
    m_g  = 32'h0;
    m_b  = 1'b0;
    m_r  = RV_HI;
    m_rg = RV_HI;
  endtask

  task automatic cmp(string tag, string inst, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s/%s: got 0x%08h expected 0x%08h", tag, inst, act, exp);
    end
  endtask

  task automatic check_all(exp_t e);
    cmp(e.tag, "s32_mux",   dout_s,  e.s);
    cmp(e.tag, "s32_gated", dout_g,  e.g);
    cmp(e.tag, "w1_mux",    {31'b0, dout_b}, {31'b0, e.b});
    cmp(e.tag, "rv_mux",    dout_r,  e.r);
    cmp(e.tag, "rv_gated",  dout_rg, e.rg);
  endtask

  // Edge monitor: one expectation per rising edge, sampled 1 ns after it.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (edge_q.size() > 0) check_all(edge_q.pop_front());
    end
  end

  // Reset monitor: reset must act without any clock edge.
  initial begin
    forever begin
      @(posedge rst);
      #1;
      if (async_q.size() > 0) check_all(async_q.pop_front());
    end
  end

  // Drive one cycle at the falling edge and predict the result of the next rise.
  task automatic drive(bit r, bit e, bit sm, logic [31:0] d, string tag);
    @(negedge clk);
    if (r && rst !== 1'b1) begin
      model_reset();
      async_q.push_back(snap({tag, "_async"}));
    end
    rst       = r;
    en        = e;
    scan_mode = sm;
    din       = d;
    if (r) begin
      model_reset();
    end else begin
      if (e) begin
        m_s = d;
        m_b = d[0];
        m_r = d;
      end
      if (e || sm) begin
        m_g  = d;
        m_rg = d;
      end
    end
    edge_q.push_back(snap(tag));
  endtask

  task automatic rst_mid_high(string tag);
    @(posedge clk);
    #3;
    model_reset();
    async_q.push_back(snap(tag));
    rst = 1'b1;
  endtask

  // en pulse entirely inside the clock-high phase; the model does not change.
  task automatic en_glitch_high();
    @(posedge clk);
    #2;
    en = 1'b1;
    #1;
    en = 1'b0;
  endtask

  initial begin
    rst       = 1'b0;
    en        = 1'b0;
    scan_mode = 1'b0;
    din       = 32'h0;

    #2;
    model_reset();
    async_q.push_back(snap("t1_reset_no_edge"));
    rst = 1'b1;

    drive(1'b1, 1'b0, 1'b0, 32'h0, "t1_reset_held");
    drive(1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF, "t1_load");
    drive(1'b0, 1'b0, 1'b0, 32'h1234_5678, "t1_hold");
    drive(1'b0, 1'b0, 1'b0, 32'h1234_5678, "t1_hold2");

    for (int i = 0; i < 4; i++) begin
      drive(1'b0, t2_en[i], 1'b0, {31'h0, t2_din[i]}, "t2_bank_id");
    end

    drive(1'b0, 1'b1, 1'b0, 32'hA5A5_A5A5, "t3_load");
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, "t3_hold");
    end
    en_glitch_high();
    drive(1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, "t3_glitch_no_load");

    drive(1'b0, 1'b0, 1'b1, 32'h0000_FFFF, "t4_scan_load");
    drive(1'b0, 1'b0, 1'b0, 32'h5555_0000, "t4_scan_off_hold");

    drive(1'b0, 1'b1, 1'b0, 32'hCAFE_F00D, "t5_preload");
    rst_mid_high("t5_reset_mid_high");
    drive(1'b0, 1'b1, 1'b0, 32'h0000_0001, "t5_release_load");
    drive(1'b0, 1'b0, 1'b0, 32'h0000_0007, "t5_hold");

    drive(1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF, "rst_wins_over_en");
    drive(1'b0, 1'b1, 1'b0, 32'h3C3C_3C3C, "after_rst_load");
    drive(1'b0, 1'b1, 1'b0, 32'hC3C3_C3C3, "en_every_cycle");
    drive(1'b0, 1'b0, 1'b0, 32'h0F0F_0F0F, "en_off");
    drive(1'b0, 1'b1, 1'b0, 32'hF0F0_F0F0, "en_on_again");

    for (int i = 0; i < 10000; i++) begin
      drive(($urandom_range(0, 199) == 0),
            ($urandom_range(0, 1) == 1),
            ($urandom_range(0, 3) == 0),
            $urandom, "t6_random");
    end

    drive(1'b0, 1'b0, 1'b0, 32'h0, "final_hold");
    @(posedge clk);
    #3;
    n_tests++;
    if (edge_q.size() != 0 || async_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d edge and %0d reset entries left, expected 0",
               edge_q.size(), async_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
